// File: rtl/instruction_memory_loader_if.sv
// Stream and byte-memory bus of the instruction memory loader.
// The loader takes the slave side; the word source and the memory take the master side.
interface instruction_memory_loader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  word_valid;
   logic [31:0]           word_data;
   logic                  word_last;
   logic                  word_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;

   modport master (
      output word_valid,
      output word_data,
      output word_last,
      input  word_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  word_valid,
      input  word_data,
      input  word_last,
      output word_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/instruction_memory_loader.sv
// Splits 32-bit instruction words into big-endian byte writes and holds the core until loaded.
// Optional running word checksum is built only when LOADER_CHECKSUM_EN is defined.
module instruction_memory_loader #(
   parameter int MEM_BYTES  = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   instruction_memory_loader_if.slave        bus,
   output logic                              busy,
   output logic                              done,
   output logic                              overflow,
   output logic                              cpu_hold,
   output logic [31:0]                       checksum
);

   localparam int BASE_W = $clog2(MEM_BYTES + 1);
   localparam logic [BASE_W-1:0] MEM_LIMIT = BASE_W'(MEM_BYTES);
   localparam logic [BASE_W-1:0] WORD_STEP = BASE_W'(4);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCEPT = 3'd1;
   localparam logic [2:0] WR0    = 3'd2;
   localparam logic [2:0] WR1    = 3'd3;
   localparam logic [2:0] WR2    = 3'd4;
   localparam logic [2:0] WR3    = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   logic [2:0]            state;
   logic [2:0]            state_next;
   logic [BASE_W-1:0]     base;
   logic [BASE_W-1:0]     base_next;
   logic [31:0]           word_reg;
   logic [31:0]           word_next;
   logic                  last_reg;
   logic                  last_next;
   logic                  overflow_reg;
   logic                  overflow_next;
   logic                  mem_we_reg;
   logic                  mem_we_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_next;
   logic [7:0]            mem_wdata_reg;
   logic [7:0]            mem_wdata_next;
   logic                  accept;
   logic                  start_load;

   assign accept     = (state == ACCEPT) && bus.word_valid;
   assign start_load = ((state == IDLE) || (state == DONE)) && start;

   always_comb begin
      state_next    = state;
      base_next     = base;
      word_next     = word_reg;
      last_next     = last_reg;
      overflow_next = overflow_reg;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next    = ACCEPT;
               base_next     = '0;
               overflow_next = 1'b0;
            end
         end
         ACCEPT: begin
            if (accept) begin
               word_next = bus.word_data;
               last_next = bus.word_last;
               if (base < MEM_LIMIT) begin
                  state_next = WR0;
               end else begin
                  // Memory is full: the word is dropped but the stream is still drained.
                  overflow_next = 1'b1;
                  state_next    = bus.word_last ? DONE : ACCEPT;
               end
            end
         end
         WR0: state_next = WR1;
         WR1: state_next = WR2;
         WR2: state_next = WR3;
         WR3: begin
            base_next  = base + WORD_STEP;
            state_next = last_reg ? DONE : ACCEPT;
         end
         default: state_next = IDLE;
      endcase
   end

   // Byte outputs are registered, so they are derived from the state being entered.
   always_comb begin
      mem_we_next    = 1'b0;
      mem_addr_next  = '0;
      mem_wdata_next = '0;
      case (state_next)
         WR0: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = ADDR_WIDTH'(base_next);
            mem_wdata_next = word_next[31:24];
         end
         WR1: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = ADDR_WIDTH'(base_next) + ADDR_WIDTH'(1);
            mem_wdata_next = word_next[23:16];
         end
         WR2: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = ADDR_WIDTH'(base_next) + ADDR_WIDTH'(2);
            mem_wdata_next = word_next[15:8];
         end
         WR3: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = ADDR_WIDTH'(base_next) + ADDR_WIDTH'(3);
            mem_wdata_next = word_next[7:0];
         end
         default: begin
            mem_we_next    = 1'b0;
            mem_addr_next  = '0;
            mem_wdata_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         base          <= '0;
         word_reg      <= '0;
         last_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state         <= state_next;
         base          <= base_next;
         word_reg      <= word_next;
         last_reg      <= last_next;
         overflow_reg  <= overflow_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] sum_reg;

   // Overflow words are summed too, so the checksum covers the whole stream received.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_reg <= '0;
      end else if (start_load) begin
         sum_reg <= '0;
      end else if (accept) begin
         sum_reg <= sum_reg + bus.word_data;
      end
   end

   assign checksum = sum_reg;
`else
   assign checksum = 32'd0;
`endif

   assign bus.word_ready = (state == ACCEPT);
   assign bus.mem_we     = mem_we_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;

   assign busy     = (state == ACCEPT) || (state == WR0) || (state == WR1) ||
                     (state == WR2) || (state == WR3);
   assign done     = (state == DONE);
   assign cpu_hold = (state != DONE);
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: a 256-byte instance and an 8-byte instance.
// Expected checksum follows LOADER_CHECKSUM_EN when the bench is built with it.
module tb_instruction_memory_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        cpu_hold;
   logic [31:0] checksum;
   logic        s_start;
   logic        s_busy;
   logic        s_done;
   logic        s_overflow;
   logic        s_cpu_hold;
   logic [31:0] s_checksum;

   int total = 0;
   int bad   = 0;
   int idle_viol = 0;

   logic [31:0] addr_log[$];
   logic [7:0]  data_log[$];
   logic [31:0] s_addr_log[$];

   instruction_memory_loader_if #(.ADDR_WIDTH(32)) bus ();
   instruction_memory_loader_if #(.ADDR_WIDTH(32)) sbus ();

   instruction_memory_loader #(.MEM_BYTES(256), .ADDR_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .cpu_hold (cpu_hold),
      .checksum (checksum)
   );

   instruction_memory_loader #(.MEM_BYTES(8), .ADDR_WIDTH(32)) dut_small (
      .clk      (clk),
      .rst      (rst),
      .start    (s_start),
      .bus      (sbus),
      .busy     (s_busy),
      .done     (s_done),
      .overflow (s_overflow),
      .cpu_hold (s_cpu_hold),
      .checksum (s_checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-side observer: logs every byte write and flags a non-zero idle bus.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         addr_log.push_back(bus.mem_addr);
         data_log.push_back(bus.mem_wdata);
      end else if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0) begin
         idle_viol++;
      end
      if (sbus.mem_we === 1'b1) s_addr_log.push_back(sbus.mem_addr);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs;
      addr_log.delete();
      data_log.delete();
      s_addr_log.delete();
   endtask

   task automatic pulse_start;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] data, input logic last, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.word_ready === 1'b1) begin
            bus.word_valid = 1'b1;
            bus.word_data  = data;
            bus.word_last  = last;
            step();
            bus.word_valid = 1'b0;
            bus.word_last  = 1'b0;
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      step();
      step();
      total++; if ({bus.word_ready, bus.mem_we, busy, done, overflow, cpu_hold} !== 6'b000001) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000001", {bus.word_ready, bus.mem_we, busy, done, overflow, cpu_hold}); end
      total++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0) begin bad++; $display("[TB] FAIL reset_bus got addr=%h data=%h want 0", bus.mem_addr, bus.mem_wdata); end
      total++; if (checksum !== 32'd0) begin bad++; $display("[TB] FAIL reset_checksum got=%h want=0", checksum); end
      total++; if ({sbus.word_ready, s_busy, s_done, s_cpu_hold} !== 4'b0001) begin bad++; $display("[TB] FAIL reset_small got=%b want=0001", {sbus.word_ready, s_busy, s_done, s_cpu_hold}); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_word;
      logic [7:0] exp_b [4] = '{8'hE3, 8'hA0, 8'h00, 8'h14};
      bit ok;
      clear_logs();
      pulse_start();
      total++; if (bus.word_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL start_to_ready got ready=%b busy=%b want 1 1", bus.word_ready, busy); end
      send_word(32'hE3A00014, 1'b1, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL single_handshake got=timeout want=accepted"); end
      for (int k = 0; k < 4; k++) begin
         total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'(k) || bus.mem_wdata !== exp_b[k]) begin bad++; $display("[TB] FAIL single_byte%0d got we=%b addr=%h data=%h want 1 %h %h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, k, exp_b[k]); end
         total++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL single_hold%0d got hold=%b done=%b want 1 0", k, cpu_hold, done); end
         step();
      end
      total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL single_done got done=%b hold=%b busy=%b we=%b want 1 0 0 0", done, cpu_hold, busy, bus.mem_we); end
      total++; if (addr_log.size() !== 4) begin bad++; $display("[TB] FAIL single_count got=%0d want=4", addr_log.size()); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] w [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
      logic [31:0] cur;
      int hs_cyc [3] = '{0, 0, 0};
      int idx = 0;
      int cyc = 0;
      bit hs;
      bit ok;
      clear_logs();
      pulse_start();
      total++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL restart_from_done got done=%b hold=%b want 0 1", done, cpu_hold); end
      bus.word_valid = 1'b1;
      bus.word_data  = w[0];
      bus.word_last  = 1'b0;
      while (idx < 3 && cyc < 60) begin
         hs = (bus.word_ready === 1'b1) && (bus.word_valid === 1'b1);
         step();
         cyc++;
         if (hs) begin
            hs_cyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               bus.word_data = w[idx];
               bus.word_last = (idx == 2);
            end else begin
               bus.word_valid = 1'b0;
               bus.word_last  = 1'b0;
            end
         end
      end
      bus.word_valid = 1'b0;
      total++; if (idx !== 3) begin bad++; $display("[TB] FAIL b2b_handshakes got=%0d want=3", idx); end
      total++; if (hs_cyc[1] - hs_cyc[0] !== 5 || hs_cyc[2] - hs_cyc[1] !== 5) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d,%0d want=5,5", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]); end
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_done got=timeout want=done"); end
      total++; if (addr_log.size() !== 12) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=12", addr_log.size()); end
      for (int i = 0; i < addr_log.size() && i < 12; i++) begin
         cur = w[i / 4];
         total++; if (addr_log[i] !== 32'(i) || data_log[i] !== cur[31 - 8 * (i % 4) -: 8]) begin bad++; $display("[TB] FAIL b2b_write%0d got addr=%h data=%h want %h %h", i, addr_log[i], data_log[i], i, cur[31 - 8 * (i % 4) -: 8]); end
      end
   endtask

   task automatic test_overflow;
      logic [31:0] w [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
      int hs_cyc [3] = '{0, 0, 0};
      int idx = 0;
      int cyc = 0;
      bit hs;
      clear_logs();
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      sbus.word_valid = 1'b1;
      sbus.word_data  = w[0];
      sbus.word_last  = 1'b0;
      while (idx < 3 && cyc < 60) begin
         hs = (sbus.word_ready === 1'b1) && (sbus.word_valid === 1'b1);
         step();
         cyc++;
         if (hs) begin
            hs_cyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               sbus.word_data = w[idx];
               sbus.word_last = (idx == 2);
            end else begin
               sbus.word_valid = 1'b0;
               sbus.word_last  = 1'b0;
            end
         end
      end
      sbus.word_valid = 1'b0;
      total++; if (idx !== 3 || hs_cyc[2] - hs_cyc[1] !== 5) begin bad++; $display("[TB] FAIL ovf_handshakes got n=%0d gap=%0d want 3 5", idx, hs_cyc[2] - hs_cyc[1]); end
      total++; if (s_done !== 1'b1 || s_cpu_hold !== 1'b0 || s_busy !== 1'b0) begin bad++; $display("[TB] FAIL ovf_done got done=%b hold=%b busy=%b want 1 0 0", s_done, s_cpu_hold, s_busy); end
      total++; if (s_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", s_overflow); end
      step();
      step();
      total++; if (s_addr_log.size() !== 8 || s_addr_log[s_addr_log.size() - 1] !== 32'd7) begin bad++; $display("[TB] FAIL ovf_writes got n=%0d want 8 ending at 7", s_addr_log.size()); end
   endtask

   task automatic test_reset_mid_load;
      bit ok;
      clear_logs();
      pulse_start();
      send_word(32'hCAFEBABE, 1'b0, ok);
      step();
      step();
      total++; if (!ok || bus.mem_addr !== 32'd2 || bus.mem_wdata !== 8'hBA) begin bad++; $display("[TB] FAIL midload_wr2 got ok=%0d addr=%h data=%h want 1 2 ba", ok, bus.mem_addr, bus.mem_wdata); end
      rst = 1'b0;
      #1;
      total++; if ({bus.word_ready, bus.mem_we, busy, done, overflow, cpu_hold} !== 6'b000001) begin bad++; $display("[TB] FAIL midload_flags got=%b want=000001", {bus.word_ready, bus.mem_we, busy, done, overflow, cpu_hold}); end
      total++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0) begin bad++; $display("[TB] FAIL midload_bus got addr=%h data=%h want 0", bus.mem_addr, bus.mem_wdata); end
      step();
      rst = 1'b1;
      bus.word_valid = 1'b1;
      bus.word_data  = 32'h12345678;
      for (int i = 0; i < 6; i++) step();
      total++; if (bus.word_ready !== 1'b0 || cpu_hold !== 1'b1 || addr_log.size() !== 2) begin bad++; $display("[TB] FAIL midload_quiet got ready=%b hold=%b writes=%0d want 0 1 2", bus.word_ready, cpu_hold, addr_log.size()); end
      bus.word_valid = 1'b0;
   endtask

   task automatic test_start_ignored;
      bit ok1;
      bit ok2;
      bit okd;
      clear_logs();
      pulse_start();
      send_word(32'h01020304, 1'b0, ok1);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      total++; if (bus.mem_addr !== 32'd2 || busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_start got addr=%h busy=%b want 2 1", bus.mem_addr, busy); end
      send_word(32'h05060708, 1'b1, ok2);
      wait_done(okd);
      total++; if (!(ok1 && ok2 && okd)) begin bad++; $display("[TB] FAIL busy_start_flow got=%0d%0d%0d want=111", ok1, ok2, okd); end
      total++; if (addr_log.size() !== 8 || addr_log[4] !== 32'd4 || data_log[4] !== 8'h05 || addr_log[7] !== 32'd7) begin bad++; $display("[TB] FAIL busy_start_addrs got n=%0d a4=%h d4=%h want 8 4 05", addr_log.size(), addr_log[4], data_log[4]); end
   endtask

   task automatic test_checksum;
      logic [31:0] exp_sum;
      bit ok1;
      bit ok2;
      bit okd;
`ifdef LOADER_CHECKSUM_EN
      exp_sum = 32'h00000001;
`else
      exp_sum = 32'h00000000;
`endif
      clear_logs();
      pulse_start();
      total++; if (checksum !== 32'd0 || done !== 1'b0) begin bad++; $display("[TB] FAIL checksum_clear got sum=%h done=%b want 0 0", checksum, done); end
      send_word(32'hFFFFFFFF, 1'b0, ok1);
      send_word(32'h00000002, 1'b1, ok2);
      wait_done(okd);
      total++; if (!(ok1 && ok2 && okd) || addr_log.size() !== 8 || addr_log[0] !== 32'd0) begin bad++; $display("[TB] FAIL checksum_flow got ok=%0d%0d%0d n=%0d want 111 8 from 0", ok1, ok2, okd, addr_log.size()); end
      total++; if (checksum !== exp_sum) begin bad++; $display("[TB] FAIL checksum_value got=%h want=%h", checksum, exp_sum); end
   endtask

   task automatic test_idle_bus;
      total++; if (idle_viol !== 0) begin bad++; $display("[TB] FAIL idle_bus_zero got=%0d want=0 cycles with addr/data set while we=0", idle_viol); end
   endtask

   initial begin
      rst             = 1'b0;
      start           = 1'b0;
      s_start         = 1'b0;
      bus.word_valid  = 1'b0;
      bus.word_data   = 32'd0;
      bus.word_last   = 1'b0;
      sbus.word_valid = 1'b0;
      sbus.word_data  = 32'd0;
      sbus.word_last  = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_reset_mid_load();
      test_start_ignored();
      test_checksum();
      test_idle_bus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Byte-wise writer that fills the processor's byte-addressed instruction memory before execution starts. It accepts 32-bit instruction words over a valid/ready stream and splits each word into four big-endian byte writes: the MSB goes to the lowest address, matching how the fetch side reassembles a word from addresses A..A+3. It holds the core in reset-hold (`cpu_hold`) until the image is fully written, then releases it.

## Interface
- `MEM_BYTES`, 256: instruction memory size in bytes; must be a multiple of 4.
- `ADDR_WIDTH`, 32: width of `mem_addr`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load at byte address 0.
- `word_valid`  in  1  source presents a word.
- `word_data`  in  32  instruction word.
- `word_last`  in  1  qualifies the final word of the image; sampled with the word.
- `word_ready`  out  1  loader can accept a word.
- `mem_we`  out  1  byte write strobe to instruction memory.
- `mem_addr`  out  ADDR_WIDTH  byte address of the write.
- `mem_wdata`  out  8  byte to write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the image is loaded; held until the next `start`.
- `overflow`  out  1  sticky flag: a word arrived when the memory was full.
- `cpu_hold`  out  1  holds the pipeline; deasserted only in DONE.
- `checksum`  out  32  running word sum (see Configuration).

## Operation
- States:
  - IDLE: waiting for a load. `start` moves to ACCEPT and clears `base`, `overflow`, `done` and `checksum`.
  - ACCEPT: `word_ready`=1. On `word_valid && word_ready`, the word and `last` are captured.
    - If `base < MEM_BYTES`: go to WR0.
    - Otherwise: set `overflow` and write nothing. Go to DONE if `last`, else stay in ACCEPT to drain the remaining words.
  - WR0..WR3: one byte per state. `mem_we`=1, `mem_addr`=`base`+k, `mem_wdata`=`word[31-8k -: 8]`. Leaving WR3 sets `base`+=4, then goes to DONE if `last`, else ACCEPT.
  - DONE: `done`=1 and `cpu_hold`=0. `start` behaves as in IDLE and restarts the load.
- Base counter: `base` is an internal counter ranging 0..`MEM_BYTES`, never wraps, and is zero-extended onto `mem_addr`.
- Ignored inputs:
  - `start` in ACCEPT or WR* states.
  - `word_valid` outside ACCEPT, since `word_ready`=0 there.
- Output values:
  - `busy` = state in {ACCEPT, WR0..WR3}.
  - `cpu_hold` = state != DONE.
- Reset values: state=IDLE, `word_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `overflow`=0, `cpu_hold`=1, `checksum`=0.
- `mem_addr`/`mem_wdata` are 0 whenever `mem_we`=0.
- Reset asserted mid-load aborts immediately. Any bytes already written stay in memory. The loader restarts only on a new `start`.

## Timing
- Outputs are registered, except `word_ready`, `busy`, `done` and `cpu_hold`, which decode the state register.
- Word accepted at edge N: `mem_we`=1 during cycles N+1..N+4 with addresses `base`..`base`+3. `word_ready` returns at cycle N+5 (or `done`, if `last`).
- Throughput: one word per 5 cycles. `start`-to-first-`word_ready`: 1 cycle.
- Last word accepted at edge N: `done`=1 and `cpu_hold`=0 from cycle N+5.
- An overflow word costs 1 cycle and produces no `mem_we`.
- `start` coinciding with the DONE→IDLE boundary is not possible; DONE persists until `start` or reset.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` is cleared on `start`.
  - `checksum` += `word_data` (mod 2^32) on every accepted word, overflow words included.
  - It updates on the edge after the handshake.
- `LOADER_CHECKSUM_EN` undefined: `checksum` is constant 0 and no adder is built.

## Test plan
- Reset then `start`, one word 0xE3A00014 with `last` → writes E3@0, A0@1, 00@2, 14@3 on 4 consecutive cycles; `done`=1 and `cpu_hold`=0 one cycle later.
- Three back-to-back words, `word_valid` held high → handshakes 5 cycles apart; second word lands at addresses 4..7; `mem_addr` never repeats.
- `MEM_BYTES`=8, three words with `last` on the third → only 8 bytes written; `overflow`=1; `done`=1 after the third handshake.
- `rst` low during WR2 of word 1 → all outputs at reset values in the same cycle; `cpu_hold`=1; no further writes until `start`.
- `start` pulsed while busy → ignored, addresses continue; `start` in DONE → `done`=0, loading restarts at 0.
- With `LOADER_CHECKSUM_EN`: words 0xFFFFFFFF and 0x00000002 → `checksum`=0x00000001. Without it: `checksum`=0 throughout.
